// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands accepted over valid/ready, summed LSB-first through one
// full-adder cell per clock, result and carry-out returned over a second valid/ready handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        st_idle = 2'b00,
        st_run  = 2'b01,
        st_done = 2'b10
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] result;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic             fa_a;
    logic             fa_b;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] sa_shift;
    logic [WIDTH-1:0] sb_shift;
    logic [WIDTH-1:0] result_shift;

    // One full-adder cell fed by the operand LSBs and the registered carry.
    assign fa_a    = sa[0];
    assign fa_b    = sb[0];
    assign fa_sum  = fa_a ^ fa_b ^ cy;
    assign fa_cout = (fa_a & fa_b) | (cy & (fa_a ^ fa_b));

    // Shifts written this way so WIDTH=1 needs no zero-width slice.
    always_comb begin
        sa_shift                  = sa >> 1;
        sb_shift                  = sb >> 1;
        result_shift              = result >> 1;
        result_shift[WIDTH-1]     = fa_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= st_idle;
            sa        <= '0;
            sb        <= '0;
            result    <= '0;
            cy        <= 1'b0;
            cnt       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                st_idle: begin
                    if (in_valid) begin
                        sa     <= a;
                        sb     <= b;
                        cy     <= c_in;
                        result <= '0;
                        cnt    <= '0;
                        state  <= st_run;
                    end
                end
                st_run: begin
                    sa     <= sa_shift;
                    sb     <= sb_shift;
                    result <= result_shift;
                    cy     <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        c_out     <= fa_cout;
                        out_valid <= 1'b1;
                        state     <= st_done;
                    end
                end
                st_done: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= st_idle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= st_idle;
                end
            endcase
        end
    end

    assign sum      = result;
    assign in_ready = (state == st_idle);
    assign busy     = (state == st_run) || (state == st_done);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (WIDTH 8, 16, 1) sharing one stimulus bus, checked
// against directed vector tables and an arithmetic reference on random operands.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a_bus = '0;
    logic [15:0] b_bus = '0;
    logic        c_bus = 1'b0;
    int          sel = 0;
    int          w;

    logic        ir8, ov8, co8, bz8;
    logic [7:0]  s8;
    logic        ir16, ov16, co16, bz16;
    logic [15:0] s16;
    logic        ir1, ov1, co1, bz1;
    logic [0:0]  s1;

    logic        m_ir, m_ov, m_co, m_busy;
    logic [15:0] m_sum;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(ir8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .c_in(c_bus), .out_valid(ov8),
        .out_ready(out_ready && sel == 0), .sum(s8), .c_out(co8), .busy(bz8)
    );

    serial_adder #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(ir16),
        .a(a_bus), .b(b_bus), .c_in(c_bus), .out_valid(ov16),
        .out_ready(out_ready && sel == 1), .sum(s16), .c_out(co16), .busy(bz16)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir1),
        .a(a_bus[0:0]), .b(b_bus[0:0]), .c_in(c_bus), .out_valid(ov1),
        .out_ready(out_ready && sel == 2), .sum(s1), .c_out(co1), .busy(bz1)
    );

    always_comb begin
        w = 8;
        m_ir = ir8; m_ov = ov8; m_co = co8; m_busy = bz8; m_sum = {8'h00, s8};
        case (sel)
            1: begin
                w = 16;
                m_ir = ir16; m_ov = ov16; m_co = co16; m_busy = bz16; m_sum = s16;
            end
            2: begin
                w = 1;
                m_ir = ir1; m_ov = ov1; m_co = co1; m_busy = bz1; m_sum = {15'h0, s1};
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] exp_sum;
        logic        exp_c;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (w=%0d, t=%0t)", nm, act, exp, w, $time);
        else
            n_pass++;
    endtask

    // Reference: plain unsigned arithmetic truncated to the active width.
    task automatic model(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         output logic [15:0] es, output logic ec);
        logic [16:0] mask;
        logic [16:0] full;
        mask = (17'd1 << w) - 17'd1;
        full = ({1'b0, ta} & mask) + ({1'b0, tb} & mask) + {16'h0, tc};
        es   = full[15:0] & mask[15:0];
        ec   = full[w];
    endtask

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!m_ir && g < 64) begin
            @(negedge clk);
            g++;
        end
        if (!m_ir) chk("in_ready timeout", 32'(m_ir), 32'd1);
    endtask

    // Count cycles from the accept edge until out_valid is seen; lat is the starting count.
    task automatic wait_out(input string nm, input int start);
        int lat = start;
        while (!m_ov && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(w + 1));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic [15:0] es, input logic ec,
                          input int stall);
        wait_ready();
        a_bus = ta; b_bus = tb; c_bus = tc; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out(nm, 0);
        chk({nm, " sum"}, 32'(m_sum), 32'(es));
        chk({nm, " c_out"}, 32'(m_co), 32'(ec));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, " hold"}, {12'h0, m_ov, m_ir, m_co, m_busy, m_sum},
                {12'h0, 1'b1, 1'b0, ec, 1'b1, es});
        end
        release_out();
        @(negedge clk);
        chk({nm, " back to idle"}, {30'h0, m_ov, m_ir}, {30'h0, 1'b0, 1'b1});
    endtask

    vec_t v8[$];
    vec_t v1[$];

    initial begin
        logic [15:0] es;
        logic        ec;
        logic [15:0] ra, rb;
        logic        rc;
        bit          saw_ov;

        v8.push_back('{16'h00, 16'h00, 1'b0, 16'h00, 1'b0});
        v8.push_back('{16'h3C, 16'h0F, 1'b0, 16'h4B, 1'b0});
        v8.push_back('{16'hFF, 16'h01, 1'b0, 16'h00, 1'b1});
        v8.push_back('{16'hA5, 16'h5A, 1'b1, 16'h00, 1'b1});
        for (int i = 0; i < 8; i++) begin
            vec_t t;
            t.a = 16'(i >> 2);
            t.b = 16'((i >> 1) & 1);
            t.c = 1'(i & 1);
            t.exp_sum = 16'(((i >> 2) ^ (i >> 1) ^ i) & 1);
            t.exp_c   = (i == 3 || i == 5 || i == 6 || i == 7);
            v1.push_back(t);
        end

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            @(negedge clk);
            chk("reset state", {27'h0, m_ir, m_ov, m_busy, m_co, |m_sum},
                {27'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end

        sel = 0;
        foreach (v8[i])
            run_op($sformatf("w8 vec%0d", i), v8[i].a, v8[i].b, v8[i].c,
                   v8[i].exp_sum, v8[i].exp_c, 2);

        // Reset on the third RUN cycle; c_out is still 1 from the last vector.
        wait_ready();
        a_bus = 16'hFF; b_bus = 16'hFF; c_bus = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst mid-run", {27'h0, m_ir, m_ov, m_busy, m_co, |m_sum},
            {27'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        saw_ov = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (m_ov) saw_ov = 1'b1;
        end
        chk("no out_valid after rst", 32'(saw_ov), 32'd0);
        run_op("post-rst 12+34", 16'h12, 16'h34, 1'b0, 16'h46, 1'b0, 0);

        // Backpressure: new operands presented while DONE is stalled must wait.
        wait_ready();
        a_bus = 16'h3C; b_bus = 16'h0F; c_bus = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_out("bp first", 0);
        a_bus = 16'h12; b_bus = 16'h34; c_bus = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp stall", {12'h0, m_ov, m_ir, m_co, m_busy, m_sum},
                {12'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4B});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp idle", {12'h0, m_ov, m_ir, m_co, m_busy, m_sum},
            {12'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4B});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp accepted", {30'h0, m_ir, m_busy}, {30'h0, 1'b0, 1'b1});
        wait_out("bp second", 1);
        chk("bp second sum", {15'h0, m_co, m_sum}, {15'h0, 1'b0, 16'h46});
        release_out();

        sel = 2;
        foreach (v1[i])
            run_op($sformatf("w1 vec%0d", i), v1[i].a, v1[i].b, v1[i].c,
                   v1[i].exp_sum, v1[i].exp_c, 1);

        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            for (int n = 0; n < 1000; n++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                model(ra, rb, rc, es, ec);
                run_op("random", ra, rb, rc, es, ec, int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
